signature_analyzer: RTL and testbench
=====================================

# signature_analyzer

Multiple-input signature register (MISR) with golden-signature check that sits directly downstream of the BIST controller. It consumes the controller's `init`, `mode`, `running` and `finish` strobes together with the parallel scan-chain outputs of the circuit under test. It compacts one scan slice per shift cycle into a signature and counts the compacted slices. After `finish` it compares both the signature and the count against parameters and reports a sticky pass/fail verdict.

## Interface
Parameters:
- `WIDTH`, 16, MISR width; also the number of scan chains observed.
- `POLY`, 16'h002D, feedback polynomial mask (bit i set means MSB feeds into bit i).
- `SEED`, 0, signature value loaded on `init`.
- `GOLDEN`, 0, expected final signature.
- `EXP_CNT`, 13, expected number of compacted slices.
- `CNT_W`, $clog2(EXP_CNT+2), slice counter width.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (reset==0 at a rising edge clears state).
- `init`  in  1  controller init strobe; arms a new run.
- `mode`  in  1  controller scan/shift-mode flag.
- `running`  in  1  controller running flag.
- `finish`  in  1  controller finish strobe; triggers the compare.
- `scan_out`  in  WIDTH  one bit per scan chain, sampled when compacting.
- `signature`  out  WIDTH  current MISR contents.
- `busy`  out  1  high in ARMED and CHECK.
- `done`  out  1  high in DONE; verdict is valid.
- `pass`  out  1  sticky; signature and count both matched.
- `fail`  out  1  sticky; mismatch on either signature or count.

## Operation
- States: IDLE=0, ARMED=1, CHECK=2, DONE=3. Encodings 3'b100 and up are unused and decode to IDLE.
- Reset (reset==0) sets the state to IDLE and clears `signature`, the counter, `busy`, `done`, `pass` and `fail` to 0. Reset overrides all other inputs.
- `init`==1 in any state (reset inactive):
  - `signature` <= SEED, counter <= 0, `pass`/`fail`/`done` <= 0, state <= ARMED.
  - `init` has priority over `running`, `mode` and `finish` in the same cycle; no compaction occurs on that cycle.
- Compaction happens only in ARMED, when `running`==1 and `mode`==1:
  - `signature` <= ({signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0)) ^ `scan_out`.
  - The counter increments and saturates at all-ones; it never wraps.
- `running`==1 with `mode`==0 (capture cycle) holds both the signature and the counter.
- ARMED with `finish`==1 moves to CHECK.
  - If compaction is enabled on the same cycle, it also occurs; CHECK then sees the updated value.
- CHECK lasts one cycle:
  - `pass` <= (signature==GOLDEN) && (counter==EXP_CNT); `fail` <= !pass.
  - State <= DONE.
- DONE holds `signature`, `pass`, `fail` and `done` until `init` or reset.
- IDLE and DONE ignore `running`, `mode`, `finish` and `scan_out`.
- `pass` and `fail` are never 1 simultaneously.

## Timing
- Compaction latency is 1 cycle: `scan_out` sampled at edge k appears in `signature` after edge k.
- `finish` high at edge t:
  - CHECK is in effect after edge t.
  - `done`, `pass` and `fail` are valid after edge t+1, one cycle after the controller raises `bist_end`.
- `busy` is registered and equals (state==ARMED || state==CHECK).
- Reset asserted mid-run (ARMED or CHECK) at edge r leaves all outputs 0 after edge r; `finish` seen later is ignored until a new `init`.
- A new `init` arriving in CHECK aborts the compare; the state returns to ARMED with cleared results.

## Test plan
- Reset: run ARMED with 2 compactions, drive reset=0 for one edge -> signature=0, busy=done=pass=fail=0; a subsequent `finish` leaves done=0.
- Nominal pass (WIDTH=4, POLY=4'h3, SEED=0, GOLDEN=4'h4, EXP_CNT=3): init, then 3 shift cycles with scan_out=8,8,1 -> signature 8, B, 4; `finish` -> done=1, pass=1, fail=0 exactly two edges after `finish`.
- Signature mismatch: same setup with scan_out=8,8,0 -> signature=5, fail=1, pass=0.
- Count check: correct data plus one running=1/mode=0 cycle -> pass=1 (count still 3). Correct data plus an extra shift with scan_out=0 -> signature=8, count=4, fail=1.
- Priority/ignore: running=mode=1 in IDLE -> signature unchanged. `init` together with running=mode=1 -> signature=SEED, count=0. `init` in DONE clears done/pass/fail on the next edge.
- Finish coincident with last shift: third shift and `finish` on the same edge -> signature=4 and pass=1.

Source files
------------

// File: rtl/signature_analyzer.sv
// signature_analyzer: MISR compactor with golden-signature and slice-count
// check, driven by the BIST controller strobes.
//
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous, active-low reset
//   init      : arms a new run (signature <= SEED, results cleared)
//   mode      : scan/shift-mode flag from the controller
//   running   : controller running flag
//   finish    : triggers the compare
//   scan_out  : one bit per scan chain, compacted in shift cycles
//   signature : current MISR contents
//   busy      : high in ARMED and CHECK
//   done      : high in DONE, verdict valid
//   pass      : sticky, signature and count matched
//   fail      : sticky, signature or count mismatched
module signature_analyzer #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = 16'h002D,
    parameter logic [WIDTH-1:0] SEED    = '0,
    parameter logic [WIDTH-1:0] GOLDEN  = '0,
    parameter int               EXP_CNT = 13,
    parameter int               CNT_W   = $clog2(EXP_CNT + 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             init,
    input  logic             mode,
    input  logic             running,
    input  logic             finish,
    input  logic [WIDTH-1:0] scan_out,
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic             busy_d;
    logic             done_d;
    logic             shift_en;
    logic             check_en;
    logic             match;
    logic [WIDTH-1:0] misr_next;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; init wins in every state, unused codes act as IDLE
    always_comb begin
        state_d = S_IDLE;
        if (init) begin
            state_d = S_ARMED;
        end else begin
            unique case (state_q)
                S_ARMED: state_d = finish ? S_CHECK : S_ARMED;
                S_CHECK: state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        busy_d   = (state_d == S_ARMED) || (state_d == S_CHECK);
        done_d   = (state_d == S_DONE);
        shift_en = !init && (state_q == S_ARMED)
                   && running && mode;
        check_en = !init && (state_q == S_CHECK);
        match    = (signature == GOLDEN)
                   && (cnt == CNT_W'(EXP_CNT));
        misr_next = {signature[WIDTH-2:0], 1'b0}
                    ^ (signature[WIDTH-1] ? POLY : '0)
                    ^ scan_out;
    end

    // Datapath and registered status flags
    always_ff @(posedge clock) begin
        if (!reset) begin
            signature <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (init) begin
                signature <= SEED;
                cnt       <= '0;
                pass      <= 1'b0;
                fail      <= 1'b0;
            end else begin
                if (shift_en) begin
                    signature <= misr_next;
                    // saturate rather than wrap so overruns stay visible
                    if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                if (check_en) begin
                    pass <= match;
                    fail <= !match;
                end
            end
        end
    end

endmodule

// File: tb/tb_signature_analyzer.sv
// tb_signature_analyzer: scoreboard bench for signature_analyzer with a
// behavioural reference model, directed scenarios and random stimulus.
module tb_signature_analyzer;

    localparam int W    = 4;
    localparam int POLY = 4'h3;
    localparam int SEED = 0;
    localparam int GOLD = 4'h4;
    localparam int EXPC = 3;
    localparam int CW   = $clog2(EXPC + 2);
    localparam int CMAX = (1 << CW) - 1;
    localparam int MASK = (1 << W) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_CHECK = 2;
    localparam int P_DONE  = 3;

    logic         clock;
    logic         reset;
    logic         init;
    logic         mode;
    logic         running;
    logic         finish;
    logic [W-1:0] scan_out;
    logic [W-1:0] signature;
    logic         busy;
    logic         done;
    logic         pass;
    logic         fail;

    typedef struct {
        int sig;
        bit busy;
        bit done;
        bit pass;
        bit fail;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    // reference model state
    int m_phase;
    int m_sig;
    int m_cnt;
    bit m_pass;
    bit m_fail;

    signature_analyzer #(
        .WIDTH   (W),
        .POLY    (4'h3),
        .SEED    (4'h0),
        .GOLDEN  (4'h4),
        .EXP_CNT (EXPC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .init      (init),
        .mode      (mode),
        .running   (running),
        .finish    (finish),
        .scan_out  (scan_out),
        .signature (signature),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // polynomial-division step: multiply by x, reduce, add the new slice
    function automatic int misr(int s, int d);
        int r;
        r = (s * 2) & MASK;
        if (s >= (1 << (W - 1))) r = r ^ POLY;
        return r ^ d;
    endfunction

    task automatic model(bit r, bit i, bit m, bit run,
                         bit f, int s);
        bit ok;
        if (!r) begin
            m_phase = P_IDLE;
            m_sig   = 0;
            m_cnt   = 0;
            m_pass  = 0;
            m_fail  = 0;
        end else if (i) begin
            m_phase = P_ARMED;
            m_sig   = SEED;
            m_cnt   = 0;
            m_pass  = 0;
            m_fail  = 0;
        end else if (m_phase == P_ARMED) begin
            if (run && m) begin
                m_sig = misr(m_sig, s);
                if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            end
            if (f) m_phase = P_CHECK;
        end else if (m_phase == P_CHECK) begin
            ok      = (m_sig == GOLD) && (m_cnt == EXPC);
            m_pass  = ok;
            m_fail  = !ok;
            m_phase = P_DONE;
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // one clock: drive at negedge, predict, push, settle after posedge
    task automatic cyc(bit r, bit i, bit m, bit run,
                       bit f, int s);
        exp_t e;
        @(negedge clock);
        reset    = r;
        init     = i;
        mode     = m;
        running  = run;
        finish   = f;
        scan_out = W'(s);
        model(r, i, m, run, f, s);
        e.sig  = m_sig;
        e.busy = (m_phase == P_ARMED) || (m_phase == P_CHECK);
        e.done = (m_phase == P_DONE);
        e.pass = m_pass;
        e.fail = m_fail;
        sb.push_back(e);
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic shift(int s);
        cyc(1, 0, 1, 1, 0, s);
    endtask

    // monitor: compare every presented output cycle against the queue
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                bad = (int'(signature) != e.sig)
                      || (busy != e.busy) || (done != e.done)
                      || (pass != e.pass) || (fail != e.fail);
                checks++;
                if (bad) begin
                    failures++;
                    $display({"FAIL scoreboard t=%0t: got sig=%0h",
                              " b=%0b d=%0b p=%0b f=%0b expected",
                              " sig=%0h b=%0b d=%0b p=%0b f=%0b"},
                             $time, signature, busy, done, pass,
                             fail, e.sig, e.busy, e.done, e.pass,
                             e.fail);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        init     = 1'b0;
        mode     = 1'b0;
        running  = 1'b0;
        finish   = 1'b0;
        scan_out = '0;
        model(0, 0, 0, 0, 0, 0);

        // reset state
        cyc(0, 0, 0, 0, 0, 0);
        chk("reset_sig", int'(signature), 0);
        chk("reset_flags", {busy, done, pass, fail}, 0);

        // reset mid-run, later finish ignored
        cyc(1, 1, 0, 0, 0, 0);
        shift(8);
        shift(8);
        cyc(0, 0, 0, 0, 0, 0);
        chk("midrst_sig", int'(signature), 0);
        chk("midrst_busy", busy, 0);
        cyc(1, 0, 0, 0, 1, 0);
        idle();
        chk("midrst_done", done, 0);

        // IDLE ignores shift
        shift(15);
        chk("idle_shift", int'(signature), 0);

        // nominal pass
        cyc(1, 1, 0, 0, 0, 0);
        chk("init_busy", busy, 1);
        shift(8);
        chk("nom_sig1", int'(signature), 8);
        shift(8);
        chk("nom_sig2", int'(signature), 11);
        shift(1);
        chk("nom_sig3", int'(signature), 4);
        cyc(1, 0, 0, 0, 1, 0);
        chk("nom_done_t", done, 0);
        idle();
        chk("nom_done", done, 1);
        chk("nom_pass", pass, 1);
        chk("nom_fail", fail, 0);

        // init in DONE clears verdict
        cyc(1, 1, 0, 0, 0, 0);
        chk("redo_flags", {done, pass, fail}, 0);

        // signature mismatch
        shift(8);
        shift(8);
        shift(0);
        chk("bad_sig", int'(signature), 5);
        cyc(1, 0, 0, 0, 1, 0);
        idle();
        chk("bad_fail", {pass, fail}, 1);

        // capture cycle holds count
        cyc(1, 1, 0, 0, 0, 0);
        shift(8);
        cyc(1, 0, 0, 1, 0, 7);
        shift(8);
        shift(1);
        cyc(1, 0, 0, 0, 1, 0);
        idle();
        chk("cap_pass", {pass, fail}, 2);

        // extra shift: count 4
        cyc(1, 1, 0, 0, 0, 0);
        shift(8);
        shift(8);
        shift(1);
        shift(0);
        chk("extra_sig", int'(signature), 8);
        cyc(1, 0, 0, 0, 1, 0);
        idle();
        chk("extra_fail", {pass, fail}, 1);

        // init with shift: no compaction, then clean run
        cyc(1, 1, 1, 1, 0, 15);
        chk("init_pri", int'(signature), SEED);
        shift(8);
        shift(8);
        // finish coincident with last shift
        cyc(1, 0, 1, 1, 1, 1);
        chk("coin_sig", int'(signature), 4);
        idle();
        chk("coin_pass", {pass, fail}, 2);

        // init during CHECK aborts compare
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("abort", {busy, done, pass, fail}, 8);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 59) != 0,
                $urandom_range(0, 24) == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 4) != 0,
                $urandom_range(0, 6) == 0,
                $urandom_range(0, MASK));
        end

        repeat (2) @(posedge clock);
        #2;
        chk("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
